// File: rtl/ram_uart_dump_if.sv
// ram_uart_dump_if
// Read port of the 16 x 8 byte RAM as seen by the UART dump engine.
//   rd_addr : 4-bit read address (dump -> RAM)
//   rd_en   : one-cycle read strobe (dump -> RAM)
//   rd_data : read data, valid the cycle after rd_en (RAM -> dump)
// master modport belongs to the dump engine, slave modport to the RAM.
interface ram_uart_dump_if;
  logic [3:0] rd_addr;
  logic       rd_en;
  logic [7:0] rd_data;

  modport master (output rd_addr, output rd_en, input rd_data);
  modport slave  (input rd_addr, input rd_en, output rd_data);
endinterface

// File: rtl/ram_uart_dump.sv
// ram_uart_dump
// On a start request, reads the 16 RAM bytes and sends them out on an 8N1
// UART line, LSB first. The frame is: sync byte 0xA5, RAM[0..15], then the
// 8-bit modulo-256 sum of the 16 data bytes. The 18 byte slots follow each
// other with no idle gap.
// Ports:
//   clk   : system clock, rising edge
//   rst   : synchronous active-high reset
//   start : dump request, only honoured in IDLE
//   ram   : RAM read port (master side of ram_uart_dump_if)
//   tx    : UART serial output, idle high
//   busy  : high while a dump is in progress
//   done  : one-cycle pulse after the final stop bit
module ram_uart_dump #(
  parameter int CLK_FREQ  = 27,
  parameter int UART_FREQ = 115200
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  ram_uart_dump_if.master ram,
  output logic            tx,
  output logic            busy,
  output logic            done
);

  localparam int BIT_CYCLES = CLK_FREQ * 1000000 / UART_FREQ;
  localparam int BAUD_W     = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BIT_CYCLES - 1);
  localparam logic [7:0] SYNC_BYTE      = 8'hA5;
  localparam logic [4:0] CSUM_SLOT_PREV = 5'd16;
  localparam logic [4:0] LAST_SLOT      = 5'd17;
  localparam logic [4:0] LAST_READ_PREV = 5'd15;
  localparam logic [3:0] LAST_DATA_BIT  = 4'd8;
  localparam logic [3:0] STOP_BIT       = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Running checksum step: 8-bit add naturally wraps modulo 256.
  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] data);
    return acc + data;
  endfunction

  state_e            state_r, state_s;
  logic [BAUD_W-1:0] baud_r, baud_s;
  logic [3:0]        bit_r, bit_s;      // 0 = start, 1..8 = data, 9 = stop
  logic [4:0]        slot_r, slot_s;    // 0 = sync, 1..16 = data, 17 = checksum
  logic [7:0]        cur_r, cur_s;      // byte currently on the line
  logic [7:0]        next_r, next_s;    // prefetched byte for the following slot
  logic [7:0]        csum_r, csum_s;
  logic              cap_r, cap_s;      // rd_data is valid this cycle
  logic              tx_r, tx_s;
  logic              busy_r, busy_s;
  logic              done_r, done_s;
  logic              rd_en_r, rd_en_s;
  logic [3:0]        rd_addr_r, rd_addr_s;

  // Next-state and next-output logic for the dump sequencer.
  always_comb begin
    state_s   = state_r;
    baud_s    = baud_r;
    bit_s     = bit_r;
    slot_s    = slot_r;
    cur_s     = cur_r;
    next_s    = next_r;
    csum_s    = csum_r;
    cap_s     = rd_en_r;
    tx_s      = tx_r;
    busy_s    = busy_r;
    done_s    = 1'b0;
    rd_en_s   = 1'b0;
    rd_addr_s = rd_addr_r;

    // A read issued last cycle returns its byte now.
    if (cap_r) begin
      next_s = ram.rd_data;
      csum_s = csum_add(csum_r, ram.rd_data);
    end else begin
      next_s = next_r;
    end

    case (state_r)
      ST_IDLE: begin
        tx_s   = 1'b1;
        busy_s = 1'b0;
        if (start) begin
          state_s   = ST_SEND;
          baud_s    = '0;
          bit_s     = 4'd0;
          slot_s    = 5'd0;
          cur_s     = SYNC_BYTE;
          csum_s    = 8'h00;
          tx_s      = 1'b0;
          busy_s    = 1'b1;
          rd_en_s   = 1'b1;
          rd_addr_s = 4'd0;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_SEND: begin
        if (baud_r == BAUD_LAST) begin
          baud_s = '0;
          if (bit_r == STOP_BIT) begin
            if (slot_r == LAST_SLOT) begin
              state_s = ST_DONE;
              tx_s    = 1'b1;
              busy_s  = 1'b0;
              done_s  = 1'b1;
            end else begin
              // Next slot starts immediately; its start bit also issues the
              // read for the byte that follows it.
              slot_s = slot_r + 5'd1;
              bit_s  = 4'd0;
              tx_s   = 1'b0;
              cur_s  = (slot_r == CSUM_SLOT_PREV) ? csum_r : next_r;
              if (slot_r < LAST_READ_PREV) begin
                rd_en_s   = 1'b1;
                rd_addr_s = slot_r[3:0] + 4'd1;
              end else begin
                rd_en_s = 1'b0;
              end
            end
          end else begin
            bit_s = bit_r + 4'd1;
            tx_s  = (bit_r == LAST_DATA_BIT) ? 1'b1 : cur_r[bit_r[2:0]];
          end
        end else begin
          baud_s = baud_r + BAUD_W'(1);
        end
      end

      ST_DONE: begin
        state_s = ST_IDLE;
        tx_s    = 1'b1;
        busy_s  = 1'b0;
      end

      default: begin
        state_s = ST_IDLE;
        tx_s    = 1'b1;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      baud_r    <= '0;
      bit_r     <= 4'd0;
      slot_r    <= 5'd0;
      cur_r     <= 8'h00;
      next_r    <= 8'h00;
      csum_r    <= 8'h00;
      cap_r     <= 1'b0;
      tx_r      <= 1'b1;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      rd_en_r   <= 1'b0;
      rd_addr_r <= 4'd0;
    end else begin
      state_r   <= state_s;
      baud_r    <= baud_s;
      bit_r     <= bit_s;
      slot_r    <= slot_s;
      cur_r     <= cur_s;
      next_r    <= next_s;
      csum_r    <= csum_s;
      cap_r     <= cap_s;
      tx_r      <= tx_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
      rd_en_r   <= rd_en_s;
      rd_addr_r <= rd_addr_s;
    end
  end

  assign tx          = tx_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign ram.rd_en   = rd_en_r;
  assign ram.rd_addr = rd_addr_r;

endmodule

// File: tb/tb_ram_uart_dump.sv
// tb_ram_uart_dump
// Two instances: dut_d at default parameters (234 cycles/bit) for the
// absolute timing figures, dut_f at 7 cycles/bit for the remaining scenarios.
// Each scenario records tx/busy/done/rd_en/rd_addr per cycle after the start
// pulse and compares against the frame predicted from the RAM contents.
module tb_ram_uart_dump;
  localparam int BC_D = 27 * 1000000 / 115200;
  localparam int BC_F = 1 * 1000000 / 142857;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_d, rst_f, start_d, start_f;
  logic tx_d, tx_f, busy_d, busy_f, done_d, done_f;
  ram_uart_dump_if if_d ();
  ram_uart_dump_if if_f ();
  logic [7:0] mem_d [16];
  logic [7:0] mem_f [16];

  ram_uart_dump dut_d (.clk(clk), .rst(rst_d), .start(start_d), .ram(if_d),
                       .tx(tx_d), .busy(busy_d), .done(done_d));
  ram_uart_dump #(.CLK_FREQ(1), .UART_FREQ(142857)) dut_f (
    .clk(clk), .rst(rst_f), .start(start_f), .ram(if_f),
    .tx(tx_f), .busy(busy_f), .done(done_f));

  // Synchronous-read RAM models: data appears the cycle after rd_en.
  always @(posedge clk) if (if_d.rd_en) if_d.rd_data <= mem_d[if_d.rd_addr];
  always @(posedge clk) if (if_f.rd_en) if_f.rd_data <= mem_f[if_f.rd_addr];

  int total = 0;
  int bad = 0;
  bit sel = 1'b0;
  logic tq[$], bq[$], dq[$], rq[$];
  logic [3:0] aq[$];
  logic [7:0] exp_b [18];

  task automatic drive(input logic s, input logic r);
    if (sel) begin start_f = s; rst_f = r; end
    else begin start_d = s; rst_d = r; end
  endtask

  // Pulse start, then record n cycles; index i is cycle t+i.
  task automatic run_dump(input int bc, input int rp1, input int rp2, input int rst_at);
    int n;
    n = 180 * bc + 31;
    tq.delete(); bq.delete(); dq.delete(); rq.delete(); aq.delete();
    tq.push_back(1'b1); bq.push_back(1'b0); dq.push_back(1'b0); rq.push_back(1'b0); aq.push_back(4'd0);
    exp_b[0] = 8'hA5;
    exp_b[17] = 8'h00;
    for (int k = 0; k < 16; k++) begin
      exp_b[k+1] = sel ? mem_f[k] : mem_d[k];
      exp_b[17] = exp_b[17] + exp_b[k+1];
    end
    @(negedge clk);
    drive(1'b1, 1'b0);
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      tq.push_back(sel ? tx_f : tx_d);
      bq.push_back(sel ? busy_f : busy_d);
      dq.push_back(sel ? done_f : done_d);
      rq.push_back(sel ? if_f.rd_en : if_d.rd_en);
      aq.push_back(sel ? if_f.rd_addr : if_d.rd_addr);
      drive((i == rp1) || (i == rp2), i == rst_at);
    end
    drive(1'b0, 1'b0);
  endtask

  // Number of cycles in 1..last where tx differs from the ideal 8N1 frame.
  function automatic int wave_errs(input int bc, input int last);
    int e = 0;
    int p, s, b;
    logic ev;
    for (int i = 1; i <= last; i++) begin
      p = (i - 1) / bc; s = p / 10; b = p % 10;
      if (s >= 18) ev = 1'b1;
      else if (b == 0) ev = 1'b0;
      else if (b == 9) ev = 1'b1;
      else ev = exp_b[s][b-1];
      if (tq[i] !== ev) e++;
    end
    return e;
  endfunction

  // Number of cycles whose read strobe/address differ from one read per slot start 0..15.
  function automatic int rd_errs(input int bc, input int upto);
    int e = 0;
    logic ex;
    for (int i = 1; i < rq.size(); i++) begin
      ex = ((i - 1) % (10 * bc) == 0) && ((i - 1) / (10 * bc) < 16) && (i <= upto);
      if (rq[i] !== ex) e++;
      else if (ex && (aq[i] !== 4'((i - 1) / (10 * bc)))) e++;
    end
    return e;
  endfunction

  // UART receiver view: sample each data bit in the middle of its bit time.
  function automatic logic [7:0] decode(input int bc, input int s);
    logic [7:0] v;
    for (int b = 0; b < 8; b++) v[b] = tq[(10 * s + b + 1) * bc + bc / 2 + 1];
    return v;
  endfunction

  function automatic int first_done();
    for (int i = 1; i < dq.size(); i++) if (dq[i] === 1'b1) return i;
    return -1;
  endfunction

  function automatic int count_ones(input int from, input int which);
    int c = 0;
    for (int i = from; i < dq.size(); i++) begin
      if (which == 0 && dq[i] !== 1'b0) c++;
      if (which == 1 && bq[i] !== 1'b0) c++;
      if (which == 2 && tq[i] !== 1'b1) c++;
    end
    return c;
  endfunction

  task automatic test_reset();
    int nb = 0;
    rst_d = 1'b1; rst_f = 1'b1; start_d = 1'b1; start_f = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if ({tx_d, busy_d, done_d, if_d.rd_en} !== 4'b1000) begin
        bad++; $display("FAIL reset_d tx/busy/done/rd_en got=%b exp=1000", {tx_d, busy_d, done_d, if_d.rd_en});
      end
      total++;
      if ({tx_f, busy_f, done_f, if_f.rd_en} !== 4'b1000) begin
        bad++; $display("FAIL reset_f tx/busy/done/rd_en got=%b exp=1000", {tx_f, busy_f, done_f, if_f.rd_en});
      end
    end
    rst_d = 1'b0; rst_f = 1'b0; start_d = 1'b0; start_f = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (busy_d || busy_f || if_d.rd_en || if_f.rd_en || !tx_d || !tx_f || done_d || done_f) nb++;
    end
    total++;
    if (nb !== 0) begin bad++; $display("FAIL reset_release activity_cycles got=%0d exp=0", nb); end
  endtask

  task automatic test_default_increment();
    int z = 0;
    int e;
    sel = 1'b0;
    for (int k = 0; k < 16; k++) mem_d[k] = 8'(k);
    run_dump(BC_D, -1, -1, -1);
    total++;
    if ({tq[1], bq[1]} !== 2'b01) begin bad++; $display("FAIL def_first_cycle tx,busy got=%b exp=01", {tq[1], bq[1]}); end
    while (z < 1000 && tq[z+1] === 1'b0) z++;
    total++;
    if (z !== 234) begin bad++; $display("FAIL def_start_bit_len got=%0d exp=234", z); end
    total++;
    if ({tq[2340], tq[2341]} !== 2'b10) begin bad++; $display("FAIL def_slot_boundary got=%b exp=10", {tq[2340], tq[2341]}); end
    e = wave_errs(BC_D, tq.size() - 1);
    total++;
    if (e !== 0) begin bad++; $display("FAIL def_waveform bad_cycles got=%0d exp=0", e); end
    for (int s = 0; s < 17; s++) begin
      total++;
      if (decode(BC_D, s) !== ((s == 0) ? 8'hA5 : 8'(s - 1))) begin
        bad++; $display("FAIL def_byte%0d got=%h exp=%h", s, decode(BC_D, s), (s == 0) ? 8'hA5 : 8'(s - 1));
      end
    end
    total++;
    if (decode(BC_D, 17) !== 8'h78) begin bad++; $display("FAIL def_checksum got=%h exp=78", decode(BC_D, 17)); end
    e = rd_errs(BC_D, tq.size());
    total++;
    if (e !== 0) begin bad++; $display("FAIL def_reads bad_cycles got=%0d exp=0", e); end
    total++;
    if (first_done() !== 42121) begin bad++; $display("FAIL def_done_cycle got=%0d exp=42121", first_done()); end
    total++;
    if (bq[42121] !== 1'b0 || bq[42120] !== 1'b1) begin
      bad++; $display("FAIL def_busy_at_done got=%b%b exp=10", bq[42120], bq[42121]);
    end
    total++;
    if (count_ones(1, 0) !== 1) begin bad++; $display("FAIL def_done_pulses got=%0d exp=1", count_ones(1, 0)); end
  endtask

  task automatic test_const_fill(input logic [7:0] fill, input logic [7:0] csum);
    int e = 0;
    sel = 1'b1;
    for (int k = 0; k < 16; k++) mem_f[k] = fill;
    run_dump(BC_F, -1, -1, -1);
    for (int s = 1; s < 17; s++) if (decode(BC_F, s) !== fill) e++;
    total++;
    if (e !== 0) begin bad++; $display("FAIL fill_%h data_bytes bad got=%0d exp=0", fill, e); end
    total++;
    if (decode(BC_F, 17) !== csum) begin bad++; $display("FAIL fill_%h checksum got=%h exp=%h", fill, decode(BC_F, 17), csum); end
    total++;
    if (wave_errs(BC_F, tq.size() - 1) !== 0) begin
      bad++; $display("FAIL fill_%h waveform got=%0d exp=0", fill, wave_errs(BC_F, tq.size() - 1));
    end
    total++;
    if (first_done() !== 180 * BC_F + 1) begin bad++; $display("FAIL fill_%h done_cycle got=%0d exp=%0d", fill, first_done(), 180 * BC_F + 1); end
  endtask

  task automatic test_ignore_start();
    int dn = 180 * BC_F + 1;
    sel = 1'b1;
    for (int k = 0; k < 16; k++) mem_f[k] = 8'($urandom);
    run_dump(BC_F, 21 * BC_F + 2, dn, -1);
    total++;
    if (count_ones(1, 0) !== 1) begin bad++; $display("FAIL ign_done_pulses got=%0d exp=1", count_ones(1, 0)); end
    total++;
    if (rd_errs(BC_F, tq.size()) !== 0) begin bad++; $display("FAIL ign_reads bad_cycles got=%0d exp=0", rd_errs(BC_F, tq.size())); end
    total++;
    if (count_ones(dn, 1) !== 0) begin bad++; $display("FAIL ign_busy_after_done got=%0d exp=0", count_ones(dn, 1)); end
    total++;
    if (wave_errs(BC_F, tq.size() - 1) !== 0) begin
      bad++; $display("FAIL ign_waveform got=%0d exp=0", wave_errs(BC_F, tq.size() - 1));
    end
  endtask

  task automatic test_mid_reset();
    int ra = 43 * BC_F + 3;
    int e = 0;
    sel = 1'b1;
    for (int k = 0; k < 16; k++) mem_f[k] = 8'($urandom);
    run_dump(BC_F, -1, -1, ra);
    total++;
    if ({tq[ra+1], bq[ra+1]} !== 2'b10) begin bad++; $display("FAIL mrst_next_cycle tx,busy got=%b exp=10", {tq[ra+1], bq[ra+1]}); end
    total++;
    if (first_done() !== -1) begin bad++; $display("FAIL mrst_done_seen at=%0d exp=none", first_done()); end
    total++;
    if (count_ones(ra + 1, 1) + count_ones(ra + 1, 2) !== 0) begin
      bad++; $display("FAIL mrst_quiet_after busy_or_tx_low got=%0d exp=0", count_ones(ra + 1, 1) + count_ones(ra + 1, 2));
    end
    total++;
    if (wave_errs(BC_F, ra) + rd_errs(BC_F, ra) !== 0) begin
      bad++; $display("FAIL mrst_before_reset got=%0d exp=0", wave_errs(BC_F, ra) + rd_errs(BC_F, ra));
    end
    for (int k = 0; k < 16; k++) mem_f[k] = 8'($urandom);
    run_dump(BC_F, -1, -1, -1);
    for (int s = 0; s < 18; s++) if (decode(BC_F, s) !== exp_b[s]) e++;
    total++;
    if (e !== 0) begin bad++; $display("FAIL mrst_redump bytes_bad got=%0d exp=0", e); end
    total++;
    if (first_done() !== 180 * BC_F + 1) begin bad++; $display("FAIL mrst_redump_done got=%0d exp=%0d", first_done(), 180 * BC_F + 1); end
  endtask

  task automatic test_back_to_back();
    int e;
    sel = 1'b1;
    for (int r = 0; r < 3; r++) begin
      e = 0;
      for (int k = 0; k < 16; k++) mem_f[k] = 8'($urandom);
      run_dump(BC_F, -1, -1, -1);
      for (int s = 0; s < 18; s++) if (decode(BC_F, s) !== exp_b[s]) e++;
      total++;
      if (e !== 0) begin bad++; $display("FAIL b2b%0d bytes_bad got=%0d exp=0", r, e); end
      e = wave_errs(BC_F, tq.size() - 1) + rd_errs(BC_F, tq.size());
      total++;
      if (e !== 0) begin bad++; $display("FAIL b2b%0d wave_or_reads got=%0d exp=0", r, e); end
      total++;
      if (first_done() !== 180 * BC_F + 1) begin bad++; $display("FAIL b2b%0d done_cycle got=%0d exp=%0d", r, first_done(), 180 * BC_F + 1); end
    end
  endtask

  initial begin
    test_reset();
    test_default_increment();
    test_const_fill(8'hFF, 8'hF0);
    test_const_fill(8'h00, 8'h00);
    test_ignore_start();
    test_mid_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ram_uart_dump.md
Name: ram_uart_dump

Overview:
- Readback path for the UART-loaded byte RAM: on a start pulse it reads all 16 RAM locations and transmits them over a UART TX line.
- Frame format: sync byte 0xA5, 16 data bytes (address 0..15), 8-bit checksum.
- Serialisation is 8N1, LSB first. The serialiser and baud counter are built in.
- Sits beside the UART write path on the RAM's read port and drives the board TX pin.

Parameters:
- CLK_FREQ, 27, system clock in MHz.
- UART_FREQ, 115200, baud rate in Hz.
- BIT_CYCLES (localparam), CLK_FREQ*1000000/UART_FREQ with integer truncation; equals 234 at defaults.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  dump request; sampled only in IDLE.
- rd_addr  out  4  RAM read address.
- rd_en  out  1  RAM read strobe; one cycle per address.
- rd_data  in  8  RAM read data; valid the cycle after rd_en.
- tx  out  1  UART serial output; idle high.
- busy  out  1  high while a dump is in progress.
- done  out  1  one-cycle pulse when a dump completes.

Behaviour:
- Reset values (the cycle after rst is sampled high): tx=1, busy=0, done=0, rd_en=0, rd_addr=0. Checksum, byte counter, bit counter and baud counter are cleared. State is IDLE.
- rst overrides everything, including mid-frame. tx returns high the next cycle. No done pulse is produced.
- States:
  - IDLE -> SEND on start=1.
  - SEND steps through byte slots 0..17: slot 0 = 0xA5, slots 1..16 = RAM[0..15], slot 17 = checksum.
  - SEND -> DONE after the slot-17 stop bit.
  - DONE -> IDLE after one cycle.
- Start timing: start high in IDLE at cycle t gives busy=1 and tx=0 (start bit of slot 0) at cycle t+1. start is ignored whenever busy=1 or done=1.
- Frame: start bit 0, data bits d0..d7, stop bit 1. Each bit is held on tx for exactly BIT_CYCLES cycles, so one frame is 10*BIT_CYCLES cycles.
- Slot spacing: slots are back-to-back. The start bit of slot n+1 begins in the cycle after the last stop-bit cycle of slot n; there is no idle gap.
- Prefetch:
  - In the first cycle of slot n's start bit, for n = 0..15: rd_en=1 and rd_addr=n.
  - rd_data is captured the following cycle into the next-byte register, which is transmitted as slot n+1.
  - rd_en is 0 in all other cycles. No read is issued during slots 16 and 17.
- Checksum: 8-bit sum modulo 256 of the 16 captured data bytes; the sync byte is excluded. It is cleared on each accepted start.
- Completion: the last stop bit of slot 17 ends at cycle t+18*10*BIT_CYCLES. In the next cycle, done=1 for one cycle and busy=0; tx stays 1.
- Total latency at defaults: start sampled at t, done at t+42121.
- The transmitted data is what rd_data returned at capture time. A RAM write racing the dump is not blocked; a concurrent write may give a mixed snapshot.
- Counter widths: the baud counter must hold BIT_CYCLES-1 and wrap to 0 at each bit boundary. The bit index runs 0..9 and the slot index 0..17; neither wraps past its terminal value.

Test Plan:
- Reset: hold rst=1 for 3 cycles with start=1 -> tx=1, busy=0, done=0, rd_en=0 throughout, and no dump starts after rst releases while start is held low.
- RAM[k]=k (k=0..15), pulse start at t -> tx decodes as A5, 00..0F, 78. rd_en pulses 16 times with rd_addr 0..15 ascending. done=1 exactly at t+42121, busy low the same cycle.
- Bit timing at defaults: the first start bit is low for exactly 234 cycles starting at t+1. Each slot is 2340 cycles with no gap between slots.
- RAM all 0xFF -> 16 bytes FF, then checksum F0. RAM all 0x00 -> checksum 00.
- start re-pulsed at t+5000 and t+42121 (the done cycle) -> both ignored: no second dump and no extra rd_en.
- rst asserted at t+10000 (mid-slot 4) -> tx=1 next cycle, busy=0, no done pulse. A new start then produces a complete correct dump.
